// File: rtl/fpmul_sched_pkg.sv
// Shared types and helpers for the fpmul round-robin scheduler.
package fpmul_sched_pkg;

    localparam int FP_W      = 32;
    localparam int TAG_MAX_W = 3;

    function automatic int tag_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Tag field is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/fpmul_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wraps, and advances past the winner.
module rr_arbiter
    import fpmul_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = tag_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            j;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpmul_sched.sv
// Shares one pipelined fpmul among NREQ requesters; a tag shift register routes products back.
module fpmul_sched
    import fpmul_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [31:0]        mul_c,
    input  logic               mul_omu,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               rsp_omu,
    output logic               busy
);

    localparam int TW = tag_w(NREQ);

    // Handshake: requester i transfers when req_valid[i] && req_ready[i];
    // responses are single-cycle pulses with no backpressure.
    logic [NREQ-1:0] gnt;
    logic [TW-1:0]   gnt_idx;
    logic            hs;

    assign req_ready = gnt;
    assign hs        = |(req_valid & gnt);

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .adv     (hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    logic [FP_W-1:0] mul_a_q, mul_a_d;
    logic [FP_W-1:0] mul_b_q, mul_b_d;
    tag_stage_t      stage0_d;

    always_comb begin
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        stage0_d = '0;
        if (hs) begin
            mul_a_d        = req_a[int'(gnt_idx)*FP_W +: FP_W];
            mul_b_d        = req_b[int'(gnt_idx)*FP_W +: FP_W];
            stage0_d.valid = 1'b1;
            stage0_d.tag   = TAG_MAX_W'(gnt_idx);
        end
    end

    // Stage 0 sits beside the operand registers; stages 1..LAT track the
    // fpmul's internal latency, so stage LAT lines up with mul_c.
    tag_stage_t tag_q [0:LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            tag_q[0] <= stage0_d;
            for (int s = 1; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    always_comb begin
        rsp_valid = '0;
        if (tag_q[LAT].valid) begin
            rsp_valid = NREQ'(1) << tag_q[LAT].tag;
        end
        busy = 1'b0;
        for (int s = 0; s <= LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    assign rsp_data = mul_c;
    assign rsp_omu  = mul_omu;

endmodule

// File: tb/tb_fpmul_sched.sv
// Randomised scoreboard bench for fpmul_sched with a behavioural fpmul stand-in.
module tb_fpmul_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [31:0]         mul_c;
  logic                mul_omu;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_omu;
  logic                busy;

  fpmul_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_omu   (mul_omu),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_omu   (rsp_omu),
    .busy      (busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference single-precision multiply ----------------
  // Returns {omu, product}; zero/denormal inputs give zero, truncating rounding.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {1'b0, s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b1, s, 31'd0};
    return {1'b0, s, e[7:0], m};
  endfunction

  // fpmul stand-in: LAT register stages from mul_a/mul_b to mul_c/mul_omu.
  logic [32:0] fp_pipe [LAT];
  initial for (int s = 0; s < LAT; s++) fp_pipe[s] = '0;
  always @(posedge clk) begin
    fp_pipe[0] <= fp_mul(mul_a, mul_b);
    for (int s = 1; s < LAT; s++) fp_pipe[s] <= fp_pipe[s-1];
  end
  assign mul_c   = fp_pipe[LAT-1][31:0];
  assign mul_omu = fp_pipe[LAT-1][32];

  // ---------------- scoreboard bookkeeping ----------------
  typedef struct packed {
    logic [31:0]     due;
    logic [NREQ-1:0] who;
    logic [31:0]     data;
    logic            omu;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- requester state / driver tasks ----------------
  logic        pend [NREQ];
  logic [31:0] opa  [NREQ];
  logic [31:0] opb  [NREQ];
  int          last_gnt = -1;

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend[i];
      req_a[i*32 +: 32]   = opa[i];
      req_b[i*32 +: 32]   = opb[i];
    end
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
    apply();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    apply();
  endtask

  // Advance one cycle; a granted request is retired from its requester.
  task automatic step();
    @(posedge clk);
    #1;
    if (last_gnt >= 0) pend[last_gnt] = 1'b0;
    apply();
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // ---------------- issue model: round-robin reference ----------------
  int          ptr_m = 0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      ptr_m    = 0;
      exp_a    = '0;
      exp_b    = '0;
      last_gnt = -1;
    end else begin
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic [32:0]     r;
      exp_t            e;
      check("mul_a", 64'(mul_a), 64'(exp_a));
      check("mul_b", 64'(mul_b), 64'(exp_b));
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      end
      exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        r      = fp_mul(req_a[g*32 +: 32], req_b[g*32 +: 32]);
        e.due  = 32'(cyc + 1 + LAT);
        e.who  = exp_rdy;
        e.data = r[31:0];
        e.omu  = r[32];
        exp_q.push_back(e);
        exp_a  = req_a[g*32 +: 32];
        exp_b  = req_b[g*32 +: 32];
        ptr_m  = (g + 1) % NREQ;
      end
      last_gnt = g;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_t e;
      check("busy", 64'(busy), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.who));
        check("rsp_data",  64'(rsp_data),  64'(e.data));
        check("rsp_omu",   64'(rsp_omu),   64'(e.omu));
      end else begin
        check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      opa[i]  = '0;
      opb[i]  = '0;
    end
    apply();

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mul_a",     64'(mul_a),     64'(0));
    check("rst_mul_b",     64'(mul_b),     64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_rsp_omu",   64'(rsp_omu),   64'(0));

    // Single request from requester 2: 2.0 x 3.0
    step();
    post(2, 32'h4000_0000, 32'h4040_0000);
    step();
    repeat (LAT) step();
    @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("single_rsp_data",  64'(rsp_data),  64'(32'h40C0_0000));
    check("single_rsp_omu",   64'(rsp_omu),   64'(0));
    repeat (3) step();

    // All requesters held valid from reset: 1.5 x 1.5 everywhere
    do_reset();
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) post(i, 32'h3FC0_0000, 32'h3FC0_0000);
      end
      step();
    end
    clear_all();
    repeat (LAT + 3) step();

    // Wrap and skip: drive the pointer to 3, then only 1 and 3 valid
    post(2, rand_fp(), rand_fp());
    step();
    for (int n = 0; n < 3; n++) begin
      if (!pend[1]) post(1, rand_fp(), rand_fp());
      if (!pend[3]) post(3, rand_fp(), rand_fp());
      step();
    end
    clear_all();
    repeat (LAT + 3) step();

    // Overflow routed to requester 0
    post(0, 32'h7F00_0000, 32'h7F00_0000);
    step();
    repeat (LAT) step();
    @(negedge clk);
    check("ovf_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("ovf_rsp_omu",   64'(rsp_omu),   64'(1));
    repeat (3) step();

    // Random traffic with mixed sparse and dense request patterns
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, (n < 200) ? 1 : 4) == 0) post(i, rand_fp(), rand_fp());
      end
      step();
    end
    clear_all();
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      step();
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    // Reset one cycle after a handshake discards the in-flight multiply
    post(1, 32'h4000_0000, 32'h4000_0000);
    step();
    rst_n = 1'b0;
    clear_all();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (LAT + 4) step();
    @(negedge clk);
    check("midrst_busy",      64'(busy),      64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpmul_sched.md
# fpmul_sched

Round-robin scheduler that shares one pipelined `fpmul` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle into `fpmul`. A tag pipeline matched to the multiplier latency routes each product and its `over_mul_under` flag back to the requester that issued it. It sits between the datapath clients and the single `fpmul` datapath instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 1: `fpmul` latency, in cycles, from a change on `a`/`b` to the matching `c`/`over_mul_under`; at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: requester i has an operand pair pending.
- `req_ready` out `NREQ`: one-hot grant; handshake on requester i when `req_valid[i] && req_ready[i]`.
- `req_a` in `NREQ*32`: IEEE-754 single operand A; requester i uses bits [32i+31:32i].
- `req_b` in `NREQ*32`: operand B, packed the same way as `req_a`.
- `mul_a` out 32: registered operand to `fpmul.a`.
- `mul_b` out 32: registered operand to `fpmul.b`.
- `mul_c` in 32: `fpmul.c`.
- `mul_omu` in 1: `fpmul.over_mul_under`.
- `rsp_valid` out `NREQ`: one-hot, one-cycle pulse for the requester owning the current result.
- `rsp_data` out 32: product; meaningful only while any `rsp_valid` bit is set.
- `rsp_omu` out 1: overflow/underflow flag that accompanies `rsp_data`.
- `busy` out 1: at least one multiply is in flight.

## Operation
- **Arbitration**
  - A round-robin pointer `ptr` (range 0..NREQ-1) selects the first index with `req_valid` set, searching from `ptr` upward and wrapping.
  - The chosen index gets `req_ready`. `req_ready` is combinational from `req_valid` and `ptr`; no bit is set when no request is valid.
  - After a grant to index g, `ptr` becomes (g+1) mod NREQ, wrapping NREQ-1 to 0. With no grant, `ptr` holds.
- **Issue**
  - On a handshake, `mul_a` and `mul_b` load the granted operands.
  - An issue-valid bit and a tag (`$clog2(NREQ)` bits, the granted index) enter stage 0 of the tag pipeline.
  - Without a handshake, `mul_a` and `mul_b` hold their values and stage 0 valid is 0.
- **Tag pipeline**
  - `LAT` stages of {valid, tag} shift every cycle and cannot stall.
  - The output stage drives `rsp_valid[tag] = valid`, `rsp_data = mul_c` and `rsp_omu = mul_omu`. These are taken combinationally from `fpmul` in the cycle the tag reaches the last stage.
- **Responses**
  - Responses have no backpressure; a requester must accept its `rsp_valid` pulse.
  - Results return in issue order.
- **Busy**
  - `busy` is the OR of all tag-pipeline valid bits.
- **Simultaneous events**
  - A requester may raise `req_valid` again in the cycle its own response returns; the two events are independent.
  - Requests are sustained back-to-back at one per cycle.
- **Reset**
  - Values after reset: `ptr` = 0, all pipeline valids = 0, `mul_a` = `mul_b` = 0, `rsp_valid` = 0, `req_ready` = 0 (no valid requests), `busy` = 0.
  - Asserting reset mid-operation discards in-flight multiplies; no response is produced for them after reset releases.

## Timing
- A handshake in cycle N drives `mul_a`/`mul_b` from cycle N+1, and the response pulse occurs in cycle N+1+LAT.
- Throughput is one multiply per cycle across all requesters.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- There is no combinational path from `mul_c` to `req_ready`.

## Structure
- Package `fpmul_sched_pkg`:
  - `FP_W` = 32.
  - Tag-width function `tag_w(n)` = `$clog2(n)`, with a minimum of 1.
  - Struct `tag_stage_t` {valid, tag}.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `clk`, `rst_n`, `req[N]`, `adv`; outputs `gnt[N]` (one-hot) and `gnt_idx`.
  - Holds the pointer; `adv` is the handshake qualifier.
- `fpmul_sched` instantiates `rr_arbiter`, the operand mux/registers and the tag shift register.
- `fpmul` stays outside the block; the top-level wrapper connects the two.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req_valid` = 4'b0000, then release. Required: all outputs 0 and `busy` = 0.
- **Single request:** requester 2 sends 0x40000000 × 0x40400000 in cycle 5. Required: `mul_a`/`mul_b` change in cycle 6; `rsp_valid` = 4'b0100 and `rsp_data` = 0x40C00000 in cycle 6+LAT; `rsp_omu` = 0.
- **All requesters held valid:**
  - Required grant order from reset: 0,1,2,3,0,…
  - Operands 0x3FC00000 × 0x3FC00000 on every requester: every response is 0x40100000, pulsed to 4'b0001, 4'b0010, 4'b0100, 4'b1000 in turn.
- **Wrap and skip:** `ptr` = 3 with only requesters 1 and 3 valid. Required: grant 3, then 1, then 3.
- **Overflow:** requester 0 sends 0x7F000000 × 0x7F000000. Required: `rsp_omu` equals the `fpmul` flag (1), routed to `rsp_valid` = 4'b0001.
- **Reset mid-flight:** assert `rst_n` = 0 one cycle after a handshake, with LAT ≥ 1. Required: no `rsp_valid` pulse after release, and `busy` = 0.
